// File: rtl/lc8951_pkg.sv
// Shared types, timing defaults and chip address-register rule for the LC8951 host port.
package lc8951_pkg;

    typedef enum logic [2:0] {
        IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, FIN
    } state_t;

    localparam int SETUP_CYC_DEF  = 1;
    localparam int STROBE_CYC_DEF = 2;
    localparam int HOLD_CYC_DEF   = 1;
    localparam int CNT_W          = 8;

    localparam logic [3:0] REG_COMIN  = 4'h0;
    localparam logic [3:0] REG_IFSTAT = 4'h1;
    localparam logic [3:0] REG_DBCL   = 4'h2;
    localparam logic [3:0] REG_DBCH   = 4'h3;
    localparam logic [3:0] REG_HEAD0  = 4'h4;
    localparam logic [3:0] REG_STAT3  = 4'hF;

    // The chip only auto-increments a non-zero AR, and 15 wraps to 0 where it then sticks.
    function automatic logic [3:0] next_ar(input logic [3:0] ar);
        return (ar == 4'h0 || ar == 4'hF) ? 4'h0 : ar + 4'h1;
    endfunction

endpackage

// File: rtl/lc8951_host_if.sv
// Request/response and chip-bus signals between the CD controller, lc8951_host and the LC8951.
interface lc8951_host_if;
    logic       REQ;
    logic       WE;
    logic [3:0] ADDR;
    logic [3:0] LEN;
    logic [3:0] WDATA;
    logic       BUSY;
    logic       BEAT;
    logic [3:0] RDATA;
    logic       DONE;
    logic       nWR;
    logic       nRD;
    logic       RS;
    logic [3:0] BUS_OUT;
    logic [3:0] BUS_IN;

    modport master (
        input  REQ, WE, ADDR, LEN, WDATA, BUS_IN,
        output BUSY, BEAT, RDATA, DONE, nWR, nRD, RS, BUS_OUT
    );

    modport slave (
        output REQ, WE, ADDR, LEN, WDATA, BUS_IN,
        input  BUSY, BEAT, RDATA, DONE, nWR, nRD, RS, BUS_OUT
    );
endinterface

// File: rtl/lc8951_phase_timer.sv
// Loadable down-counter timing one bus phase; last is high in the phase's final cycle.
module lc8951_phase_timer
    import lc8951_pkg::*;
(
    input  logic             CLK_12M,
    input  logic             nRESET,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge CLK_12M) begin
        if (!nRESET)                  cnt_q <= '0;
        else if (load)                cnt_q <= load_val;
        else if (cnt_q > CNT_W'(1))   cnt_q <= cnt_q - CNT_W'(1);
    end

    assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/lc8951_host.sv
// LC8951 register-port initiator: one AR write then 1..16 auto-incremented data beats.
// Build option LC8951_HOST_SKIPADDR_EN skips the AR write when the AR mirror already matches.
module lc8951_host
    import lc8951_pkg::*;
#(
    parameter int SETUP_CYC  = SETUP_CYC_DEF,
    parameter int STROBE_CYC = STROBE_CYC_DEF,
    parameter int HOLD_CYC   = HOLD_CYC_DEF
) (
    input  logic          CLK_12M,
    input  logic          nRESET,
    lc8951_host_if.master bus
);

    state_t           state_q, state_d;
    logic             we_q;
    logic [3:0]       addr_q, len_q, cnt_q, mirror_q;
    logic             mirror_vld_q;
    logic             ph_last, entering, accept, we_now, skip;
    logic [CNT_W-1:0] ph_len;

    assign accept   = (state_q == IDLE) && bus.REQ;
    assign we_now   = accept ? bus.WE : we_q;
    assign entering = (state_d != state_q);

`ifdef LC8951_HOST_SKIPADDR_EN
    assign skip = mirror_vld_q && (mirror_q == bus.ADDR);
`else
    // Mirror is still tracked so the skip build differs only here.
    assign skip = 1'b0 && mirror_vld_q && (mirror_q == bus.ADDR);
`endif

    lc8951_phase_timer u_timer (
        .CLK_12M  (CLK_12M),
        .nRESET   (nRESET),
        .load     (entering),
        .load_val (ph_len),
        .last     (ph_last)
    );

    always_ff @(posedge CLK_12M) begin
        if (!nRESET) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (bus.REQ) state_d = skip ? D_SETUP : A_SETUP;
            A_SETUP:  if (ph_last) state_d = A_STROBE;
            A_STROBE: if (ph_last) state_d = A_HOLD;
            A_HOLD:   if (ph_last) state_d = D_SETUP;
            D_SETUP:  if (ph_last) state_d = D_STROBE;
            D_STROBE: if (ph_last) state_d = D_HOLD;
            D_HOLD:   if (ph_last) state_d = (cnt_q == len_q) ? FIN : D_SETUP;
            FIN:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        ph_len = CNT_W'(1);
        case (state_d)
            A_SETUP, D_SETUP:   ph_len = CNT_W'(SETUP_CYC);
            A_STROBE, D_STROBE: ph_len = CNT_W'(STROBE_CYC);
            A_HOLD, D_HOLD:     ph_len = CNT_W'(HOLD_CYC);
            default:            ph_len = CNT_W'(1);
        endcase
    end

    // Outputs are decoded from state_d so every pin is a flop aligned with its phase.
    always_ff @(posedge CLK_12M) begin
        if (!nRESET) begin
            bus.nWR      <= 1'b1;
            bus.nRD      <= 1'b1;
            bus.RS       <= 1'b0;
            bus.BUS_OUT  <= '0;
            bus.BUSY     <= 1'b0;
            bus.BEAT     <= 1'b0;
            bus.DONE     <= 1'b0;
            bus.RDATA    <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            mirror_q     <= '0;
            mirror_vld_q <= 1'b0;
        end else begin
            bus.BUSY <= (state_d != IDLE);
            bus.DONE <= (state_d == FIN);
            bus.nWR  <= !((state_d == A_STROBE) || (state_d == D_STROBE && we_now));
            bus.nRD  <= !(state_d == D_STROBE && !we_now);
            bus.BEAT <= 1'b0;
            if (accept) begin
                we_q   <= bus.WE;
                addr_q <= bus.ADDR;
                len_q  <= bus.LEN;
                cnt_q  <= '0;
            end
            if (entering && state_d == A_SETUP) begin
                bus.RS      <= 1'b0;
                bus.BUS_OUT <= bus.ADDR;
            end
            if (entering && state_d == D_SETUP) begin
                bus.RS <= 1'b1;
                if (we_now) begin
                    bus.BUS_OUT <= bus.WDATA;
                    bus.BEAT    <= 1'b1;
                end
            end
            if (state_q == D_STROBE && ph_last && !we_q) begin
                bus.RDATA <= bus.BUS_IN;
                bus.BEAT  <= 1'b1;
            end
            if (state_q == A_HOLD && ph_last) begin
                mirror_q     <= addr_q;
                mirror_vld_q <= 1'b1;
            end
            if (state_q == D_HOLD && ph_last) begin
                mirror_q <= next_ar(mirror_q);
                if (cnt_q != len_q) cnt_q <= cnt_q + 4'h1;
            end
        end
    end

endmodule

// File: tb/tb_lc8951_host.sv
// Directed bench for lc8951_host against a behavioural LC8951 register file.
module tb_lc8951_host;
    import lc8951_pkg::*;

`ifdef LC8951_HOST_SKIPADDR_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk    = 1'b0;
    logic nreset = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;

    lc8951_host_if bif ();

    lc8951_host dut (
        .CLK_12M (clk),
        .nRESET  (nreset),
        .bus     (bif)
    );

    always #5 clk = ~clk;

    // Chip model: acts one edge after a strobe rises, using the RS/DIN held through the hold phase.
    logic [3:0] chip_reg [16];
    logic [3:0] chip_ar  = '0;
    logic       nwr_prev = 1'b1;
    logic       nrd_prev = 1'b1;
    logic       poke     = 1'b0;
    logic [3:0] poke_a   = '0;
    logic [3:0] poke_d   = '0;

    assign bif.BUS_IN = chip_reg[chip_ar];

    always @(posedge clk) begin
        if (poke) begin
            chip_reg[poke_a] <= poke_d;
        end else if (nwr_prev === 1'b0 && bif.nWR === 1'b1) begin
            if (bif.RS === 1'b0) chip_ar <= bif.BUS_OUT;
            else begin
                chip_reg[chip_ar] <= bif.BUS_OUT;
                chip_ar           <= next_ar(chip_ar);
            end
        end else if (nrd_prev === 1'b0 && bif.nRD === 1'b1 && bif.RS === 1'b1) begin
            chip_ar <= next_ar(chip_ar);
        end
        nwr_prev <= bif.nWR;
        nrd_prev <= bif.nRD;
    end

    int         k;
    int         done_k[$];
    int         beat_k[$];
    logic [3:0] beat_rd[$];
    logic       stb_rs[$];
    logic [3:0] stb_bus[$];
    int         stb_len[$];
    logic       stb_prev;
    logic       held_rs;
    logic [3:0] held_bus;
    int         cur_len;
    int         n_overlap  = 0;
    int         n_unstable = 0;
    logic [3:0] wq[$];
    logic       feed;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic mon_clear();
        k = 0;
        done_k.delete(); beat_k.delete(); beat_rd.delete();
        stb_rs.delete(); stb_bus.delete(); stb_len.delete();
        stb_prev = 1'b0;
        cur_len  = 0;
        feed     = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        k++;
        if (!bif.nWR && !bif.nRD) n_overlap++;
        if (!bif.nWR || !bif.nRD) begin
            if (!stb_prev) begin
                stb_rs.push_back(bif.RS);
                stb_bus.push_back(bif.BUS_OUT);
                held_rs  = bif.RS;
                held_bus = bif.BUS_OUT;
                cur_len  = 1;
            end else begin
                cur_len++;
                if (bif.RS !== held_rs || bif.BUS_OUT !== held_bus) n_unstable++;
            end
            stb_prev = 1'b1;
        end else begin
            if (stb_prev) stb_len.push_back(cur_len);
            stb_prev = 1'b0;
        end
        if (bif.BEAT) begin
            beat_k.push_back(k);
            beat_rd.push_back(bif.RDATA);
        end
        if (bif.DONE) done_k.push_back(k);
    endtask

    function automatic int n_addr_stb();
        int n = 0;
        foreach (stb_rs[i]) if (stb_rs[i] == 1'b0) n++;
        return n;
    endfunction

    task automatic poke_reg(input logic [3:0] a, input logic [3:0] d);
        poke = 1'b1; poke_a = a; poke_d = d;
        @(negedge clk);
        poke = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge one cycle after DONE.
    task automatic txn(input logic we, input logic [3:0] addr, input logic [3:0] len);
        mon_clear();
        bif.REQ = 1'b1; bif.WE = we; bif.ADDR = addr; bif.LEN = len;
        if (we && wq.size() > 0) bif.WDATA = wq.pop_front();
        for (int i = 0; i < 100; i++) begin
            step();
            if (k == 1) bif.REQ = 1'b0;
            if (feed) begin
                if (wq.size() > 0) bif.WDATA = wq.pop_front();
                feed = 1'b0;
            end
            if (bif.BEAT && we) feed = 1'b1;
            if (done_k.size() > 0) break;
        end
        if (done_k.size() == 0) chk("txn_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        bif.REQ = 1'b0; bif.WE = 1'b0; bif.ADDR = '0; bif.LEN = '0; bif.WDATA = '0;
        repeat (3) @(negedge clk);
        chk("rst_nWR", bif.nWR, 1);
        chk("rst_nRD", bif.nRD, 1);
        chk("rst_RS", bif.RS, 0);
        chk("rst_BUS_OUT", bif.BUS_OUT, 0);
        chk("rst_BUSY", bif.BUSY, 0);
        chk("rst_BEAT", bif.BEAT, 0);
        chk("rst_DONE", bif.DONE, 0);
        chk("rst_RDATA", bif.RDATA, 0);
        nreset = 1'b1;
        @(negedge clk);

        // Single write beat to register 3
        wq.push_back(4'hA);
        txn(1'b1, 4'd3, 4'd0);
        chk("t1_done_cyc", done_k[0], 9);
        chk("t1_n_strobe", stb_rs.size(), 2);
        chk("t1_rs0", stb_rs[0], 0);
        chk("t1_bus0", stb_bus[0], 3);
        chk("t1_rs1", stb_rs[1], 1);
        chk("t1_bus1", stb_bus[1], 4'hA);
        chk("t1_len0", stb_len[0], 2);
        chk("t1_len1", stb_len[1], 2);
        chk("t1_n_beat", beat_k.size(), 1);
        chk("t1_beat_cyc", beat_k[0], 5);
        chk("t1_reg3", chip_reg[3], 4'hA);

        // Read burst across the 15->0 wrap
        poke_reg(4'd14, 4'd1);
        poke_reg(4'd15, 4'd2);
        poke_reg(4'd0, 4'd3);
        txn(1'b0, 4'd14, 4'd3);
        chk("t2_done_cyc", done_k[0], 21);
        chk("t2_n_beat", beat_k.size(), 4);
        chk("t2_rd0", beat_rd[0], 1);
        chk("t2_rd1", beat_rd[1], 2);
        chk("t2_rd2", beat_rd[2], 3);
        chk("t2_rd3", beat_rd[3], 3);
        chk("t2_beat0_cyc", beat_k[0], 8);
        chk("t2_beat3_cyc", beat_k[3], 20);
        chk("t2_addr_stb", n_addr_stb(), 1);
        chk("t2_bus0", stb_bus[0], 14);

        // Write burst at AR=0: AR sticks, mirror is 0 so a skip build omits the AR write
        wq.push_back(4'd5); wq.push_back(4'd6); wq.push_back(4'd7);
        txn(1'b1, 4'd0, 4'd2);
        chk("t3_done_cyc", done_k[0], SKIP ? 13 : 17);
        chk("t3_addr_stb", n_addr_stb(), SKIP ? 0 : 1);
        chk("t3_n_beat", beat_k.size(), 3);
        chk("t3_gap01", beat_k[1] - beat_k[0], 4);
        chk("t3_gap12", beat_k[2] - beat_k[1], 4);
        chk("t3_reg0", chip_reg[0], 7);
        chk("t3_chip_ar", chip_ar, 0);

        // Reset during the second read strobe
        mon_clear();
        bif.REQ = 1'b1; bif.WE = 1'b0; bif.ADDR = 4'd1; bif.LEN = 4'd3;
        for (int i = 0; i < 30; i++) begin
            step();
            if (k == 1) bif.REQ = 1'b0;
            if (k == 10) begin
                chk("t4_pre_nRD", bif.nRD, 0);
                nreset = 1'b0;
            end
            if (k == 11) begin
                chk("t4_nRD", bif.nRD, 1);
                chk("t4_BUSY", bif.BUSY, 0);
                chk("t4_DONE", bif.DONE, 0);
                nreset = 1'b1;
            end
        end
        chk("t4_n_done", done_k.size(), 0);
        chk("t4_n_beat", beat_k.size(), 1);

        // Mirror was 2 before reset; reset must force the AR write
        wq.push_back(4'd9);
        txn(1'b1, 4'd2, 4'd0);
        chk("t5_addr_stb", n_addr_stb(), 1);
        chk("t5_done_cyc", done_k[0], 9);
        chk("t5_reg2", chip_reg[2], 9);

        // AR=5 leaves the mirror at 6: ADDR=6 may skip, ADDR=2 may not
        wq.push_back(4'd1);
        txn(1'b1, 4'd5, 4'd0);
        chk("t6_reg5", chip_reg[5], 1);
        wq.push_back(4'd2);
        txn(1'b1, 4'd6, 4'd0);
        chk("t6_skip_done", done_k[0], SKIP ? 5 : 9);
        chk("t6_skip_astb", n_addr_stb(), SKIP ? 0 : 1);
        chk("t6_reg6", chip_reg[6], 2);
        wq.push_back(4'd3);
        txn(1'b1, 4'd2, 4'd0);
        chk("t6_miss_astb", n_addr_stb(), 1);
        chk("t6_miss_done", done_k[0], 9);
        chk("t6_reg2", chip_reg[2], 3);

        // REQ held high: back-to-back transactions, the second starting right after FIN
        mon_clear();
        bif.REQ = 1'b1; bif.WE = 1'b1; bif.ADDR = 4'd4; bif.LEN = 4'd0; bif.WDATA = 4'hC;
        for (int i = 0; i < 40; i++) begin
            step();
            if (k == 10) chk("t7_busy_gap", bif.BUSY, 0);
            if (k == 11) chk("t7_busy_again", bif.BUSY, 1);
            if (done_k.size() == 2) break;
        end
        bif.REQ = 1'b0;
        chk("t7_n_done", done_k.size(), 2);
        chk("t7_done0", done_k[0], 9);
        chk("t7_done1", done_k[1], 19);
        chk("t7_addr_stb", n_addr_stb(), 2);
        repeat (2) step();
        chk("t7_idle_busy", bif.BUSY, 0);
        chk("t7_n_done_end", done_k.size(), 2);
        chk("t7_reg4", chip_reg[4], 4'hC);

        chk("strobe_overlap", n_overlap, 0);
        chk("strobe_unstable", n_unstable, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
